trace_capture_buffer: RTL and testbench

- Parametrised commit-trace recorder that sits beside the monocycle core.
- Each valid cycle, it captures the core's commit record (pc, instruction, result) into a circular buffer.
- Capture stops a programmable number of records after a PC-match trigger.
- The frozen window is then drained oldest-first through a read port, replacing per-cycle $display monitoring with in-hardware trace.

---
 rtl/trace_capture_buffer_if.sv | 46 ++++
 rtl/trace_capture_buffer.sv | 143 ++++++++++++++
 tb/tb_trace_capture_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_if.sv
// Commit-record input, trigger control and drain port of the trace capture buffer.
// TRACE_TIMESTAMP_EN adds the rd_ts field and the TS_W parameter.
interface trace_capture_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
`ifdef TRACE_TIMESTAMP_EN
    , parameter int unsigned TS_W = 16
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            valid_in;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] result_in;
    logic            arm;
    logic            trig_en;
    logic [XLEN-1:0] trig_pc;
    logic            rd_en;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [XLEN-1:0] rd_result;
    logic [CW-1:0]   count;
    logic [1:0]      state;
    logic            triggered;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] rd_ts;
`endif

    modport master (
`ifdef TRACE_TIMESTAMP_EN
        input  rd_ts,
`endif
        output valid_in, pc_in, instr_in, result_in, arm, trig_en, trig_pc, rd_en,
        input  rd_valid, rd_pc, rd_instr, rd_result, count, state, triggered
    );

    modport slave (
`ifdef TRACE_TIMESTAMP_EN
        output rd_ts,
`endif
        input  valid_in, pc_in, instr_in, result_in, arm, trig_en, trig_pc, rd_en,
        output rd_valid, rd_pc, rd_instr, rd_result, count, state, triggered
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Circular commit-trace recorder: captures until POST_TRIG records after a PC match, then drains.
// Optional feature macro TRACE_TIMESTAMP_EN stores a free-running cycle stamp with each record.
module trace_capture_buffer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8
`ifdef TRACE_TIMESTAMP_EN
    , parameter int unsigned TS_W    = 16
`endif
) (
    input logic                  clk,
    input logic                  reset,
    trace_capture_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned TsW = TS_W;
`else
    localparam int unsigned TsW = 0;
`endif
    localparam int unsigned RW = 2 * XLEN + 32 + TsW;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StPost    = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_q, post_d;
    logic            trig_q, trig_d;
    logic            rd_valid_q, rd_valid_d;
    logic [RW-1:0]   rd_rec_q, rd_rec_d;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   wr_rec;
    logic            wr_en;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    assign wr_rec    = {bus.pc_in, bus.instr_in, bus.result_in, ts_q};
    assign bus.rd_ts = rd_rec_q[TS_W-1:0];
`else
    assign wr_rec    = {bus.pc_in, bus.instr_in, bus.result_in};
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        trig_d     = trig_q;
        rd_valid_d = 1'b0;
        rd_rec_d   = rd_rec_q;
        wr_en      = 1'b0;
        // arm wins over everything, including a same-cycle commit
        if (bus.arm) begin
            state_d  = StCapture;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            trig_d   = 1'b0;
        end else begin
            unique case (state_q)
                StCapture, StPost: begin
                    if (bus.valid_in) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // full: overwrite oldest, so the read pointer tracks the write pointer
                        if (count_q == CW'(DEPTH)) rd_ptr_d = rd_ptr_q + 1'b1;
                        else                       count_d  = count_q + 1'b1;
                        if (state_q == StCapture) begin
                            if (bus.trig_en && (bus.pc_in == bus.trig_pc)) begin
                                trig_d  = 1'b1;
                                post_d  = CW'(POST_TRIG);
                                state_d = (POST_TRIG == 0) ? StDone : StPost;
                            end
                        end else begin
                            post_d = post_q - 1'b1;
                            if (post_q == CW'(1)) state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.rd_en && (count_q != '0)) begin
                        rd_valid_d = 1'b1;
                        rd_rec_d   = mem_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        count_d    = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_rec_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
            rd_rec_q   <= rd_rec_d;
        end
    end

    // Storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_result = rd_rec_q[TsW +: XLEN];
    assign bus.rd_instr  = rd_rec_q[TsW + XLEN +: 32];
    assign bus.rd_pc     = rd_rec_q[TsW + XLEN + 32 +: XLEN];
    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.triggered = trig_q;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized bench for trace_capture_buffer: two instances (POST_TRIG=8 and 0) share stimulus
// and are compared every cycle against a record-log window model.
module tb_trace_capture_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int          LOGN  = 4096;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [31:0]     result;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic valid = 1'b0, arm = 1'b0, trig_en = 1'b0, rd_en = 1'b0;
    logic [31:0] pc = '0, instr = '0, result = '0, trig_pc = '0;
    logic chk_en = 1'b0;

    logic [1:0]      o_state [2];
    logic [CW-1:0]   o_count [2];
    logic            o_trig  [2];
    logic            o_rdv   [2];
    logic [31:0]     o_pc    [2];
    logic [31:0]     o_instr [2];
    logic [31:0]     o_res   [2];
    logic [TS_W-1:0] o_ts    [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trace_capture_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)
`ifdef TRACE_TIMESTAMP_EN
        , .TS_W(TS_W)
`endif
    ) bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign bus[k].valid_in  = valid;
        assign bus[k].pc_in     = pc;
        assign bus[k].instr_in  = instr;
        assign bus[k].result_in = result;
        assign bus[k].arm       = arm;
        assign bus[k].trig_en   = trig_en;
        assign bus[k].trig_pc   = trig_pc;
        assign bus[k].rd_en     = rd_en;
        assign o_state[k] = bus[k].state;
        assign o_count[k] = bus[k].count;
        assign o_trig[k]  = bus[k].triggered;
        assign o_rdv[k]   = bus[k].rd_valid;
        assign o_pc[k]    = bus[k].rd_pc;
        assign o_instr[k] = bus[k].rd_instr;
        assign o_res[k]   = bus[k].rd_result;
`ifdef TRACE_TIMESTAMP_EN
        assign o_ts[k]    = bus[k].rd_ts;
`else
        assign o_ts[k]    = '0;
`endif
        trace_capture_buffer #(
            .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG((k == 0) ? 8 : 0)
`ifdef TRACE_TIMESTAMP_EN
            , .TS_W(TS_W)
`endif
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus[k])
        );
    end

    // Model: every record written since the last arm goes into a log; the buffer is the
    // window [head, tail) of that log, at most DEPTH long.
    rec_t            mlog [2][LOGN];
    int              mhead [2];
    int              mtail [2];
    int              ms    [2];
    int              mpost [2];
    bit              mtrig [2];
    bit              mrdv  [2];
    rec_t            mrd   [2];
    logic [TS_W-1:0] mts;
    int              pt    [2] = '{8, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0; mtail[k] = 0; ms[k] = 0; mpost[k] = 0;
            mtrig[k] = 0; mrdv[k] = 0; mrd[k] = '0;
        end
        mts = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (arm) begin
                    ms[k] = 1; mhead[k] = 0; mtail[k] = 0; mtrig[k] = 0; mrdv[k] = 0; mpost[k] = 0;
                end else begin
                    mrdv[k] = 0;
                    if ((ms[k] == 1 || ms[k] == 2) && valid) begin
                        mlog[k][mtail[k] % LOGN] = '{pc, instr, result, mts};
                        mtail[k]++;
                        if (mtail[k] - mhead[k] > DEPTH) mhead[k]++;
                        if (ms[k] == 1 && trig_en && pc == trig_pc) begin
                            mtrig[k] = 1;
                            mpost[k] = pt[k];
                            ms[k] = (pt[k] == 0) ? 3 : 2;
                        end else if (ms[k] == 2) begin
                            mpost[k]--;
                            if (mpost[k] == 0) ms[k] = 3;
                        end
                    end else if (ms[k] == 3 && rd_en && mtail[k] > mhead[k]) begin
                        mrd[k] = mlog[k][mhead[k] % LOGN];
                        mhead[k]++;
                        mrdv[k] = 1;
                    end
                end
            end
            mts = mts + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset && chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("state%0d", k), 64'(o_state[k]), 64'(ms[k]));
                chk($sformatf("count%0d", k), 64'(o_count[k]), 64'(mtail[k] - mhead[k]));
                chk($sformatf("triggered%0d", k), 64'(o_trig[k]), 64'(mtrig[k]));
                chk($sformatf("rd_valid%0d", k), 64'(o_rdv[k]), 64'(mrdv[k]));
                chk($sformatf("rd_pc%0d", k), 64'(o_pc[k]), 64'(mrd[k].pc));
                chk($sformatf("rd_instr%0d", k), 64'(o_instr[k]), 64'(mrd[k].instr));
                chk($sformatf("rd_result%0d", k), 64'(o_res[k]), 64'(mrd[k].result));
`ifdef TRACE_TIMESTAMP_EN
                chk($sformatf("rd_ts%0d", k), 64'(o_ts[k]), 64'(mrd[k].ts));
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input logic [31:0] p);
        valid = 1'b1; pc = p; instr = $urandom; result = $urandom;
        cyc();
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", 64'(o_state[0]), 64'd0);
        chk("rst_count", 64'(o_count[0]), 64'd0);
        chk("rst_trig", 64'(o_trig[0]), 64'd0);
        chk("rst_rdv", 64'(o_rdv[0]), 64'd0);
        chk("rst_rd_pc", 64'(o_pc[0]), 64'd0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("init_state", 64'(o_state[0]), 64'd0);
        chk("init_count", 64'(o_count[0]), 64'd0);
        chk("init_rdv", 64'(o_rdv[0]), 64'd0);
        #9 reset = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Basic trigger at 0x10
        trig_pc = 32'h10; trig_en = 1'b1; arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rec(32'(4 * i));
            if (i == 4)  chk("t1_trig", 64'(o_trig[0]), 64'd1);
            if (i == 11) chk("t1_post", 64'(o_state[0]), 64'd2);
            if (i == 12) chk("t1_done", 64'(o_state[0]), 64'd3);
        end
        valid = 1'b0;
        chk("t1_count", 64'(o_count[0]), 64'd13);
        chk("t1_count_pt0", 64'(o_count[1]), 64'd5);
        rd_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            chk("t1_rd_pc", 64'(o_pc[0]), 64'(4 * i));
        end
        rd_en = 1'b0;

        // Wrap-around: trigger at record 30 of 40
        trig_pc = 32'(4 * 30); arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rec(32'(4 * i));
            if (i == 37) chk("t2_post", 64'(o_state[0]), 64'd2);
            if (i == 38) chk("t2_done", 64'(o_state[0]), 64'd3);
        end
        valid = 1'b0;
        chk("t2_count", 64'(o_count[0]), 64'd16);
        rd_en = 1'b1;
        cyc();
        chk("t2_first_pc", 64'(o_pc[0]), 64'(4 * 23));
        for (int i = 0; i < 13; i++) cyc();
        chk("t4_count2", 64'(o_count[0]), 64'd2);

        // Underflow: four pops with two entries left
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_rdv", 64'(o_rdv[0]), (i < 2) ? 64'd1 : 64'd0);
        end
        rd_en = 1'b0;
        chk("t4_count0", 64'(o_count[0]), 64'd0);

        // Re-arm mid-POST with a simultaneous commit
        trig_pc = 32'h8; arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) rec(32'(4 * i));
        chk("t5_in_post", 64'(o_state[0]), 64'd2);
        arm = 1'b1;
        rec(32'h40);
        arm = 1'b0; valid = 1'b0;
        chk("t5_state", 64'(o_state[0]), 64'd1);
        chk("t5_count", 64'(o_count[0]), 64'd0);
        chk("t5_trig", 64'(o_trig[0]), 64'd0);
        cyc();
        chk("t5_dropped", 64'(o_count[0]), 64'd0);

        // Async reset mid-DONE, after a pop left rd_* non-zero
        trig_pc = 32'h0;
        rec(32'h0);
        for (int i = 0; i < 8; i++) rec(32'h4);
        valid = 1'b0; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("t5_done", 64'(o_state[0]), 64'd3);
        async_reset();

`ifdef TRACE_TIMESTAMP_EN
        // Records at cycles 5, 7, 12 after reset release; POST_TRIG=0 instance drains them
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        trig_pc = 32'h100;
        for (int e = 1; e <= 12; e++) begin
            valid = (e == 5 || e == 7 || e == 12);
            pc = (e == 12) ? 32'h100 : 32'(e);
            cyc();
        end
        valid = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_ts", 64'(o_ts[1]), (i == 0) ? 64'd5 : (i == 1) ? 64'd7 : 64'd12);
        end
        rd_en = 1'b0;
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            arm = ($urandom_range(0, 99) < 2);
            if (arm) trig_pc = 32'(4 * $urandom_range(0, 15));
            trig_en = ($urandom_range(0, 7) != 0);
            valid = ($urandom_range(0, 9) < 7);
            pc = 32'(4 * $urandom_range(0, 15));
            instr = $urandom; result = $urandom;
            rd_en = $urandom_range(0, 1);
            cyc();
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        valid = 1'b0; arm = 1'b0; rd_en = 1'b0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
